// File: rtl/lsu_exe.sv
`default_nettype none
// ============================================================================
// lsu_exe : LSU execute stage, single-outstanding load/store/fence unit
// Revision: 1.0
// ============================================================================
module lsu_exe #(
  parameter int RB     = 2,
  parameter int EXE_DW = 13 + 5 + RB + 128
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              lsu_exeparam_valid,
  input  logic [EXE_DW-1:0] lsu_exeparam,
  output logic              lsu_exeparam_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [63:0]       mem_req_addr,
  output logic              mem_req_wen,
  output logic [63:0]       mem_req_wdata,
  output logic [7:0]        mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rsp_rdata,
  output logic              lsu_wb_valid,
  output logic [5+RB-1:0]   lsu_wb_rd0,
  output logic [63:0]       lsu_wb_res,
  output logic              lsu_wb_misalign,
  output logic              lsu_wb_fence_i,
  input  logic              flush
);

  localparam int c_RD_W   = 5 + RB;
  localparam int c_RD_LSB = 128;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  // Decode of the incoming beat, MSB-first flag vector lb..fence
  logic [12:0]       w_flg;
  logic [c_RD_W-1:0] w_rd0;
  logic [63:0]       w_op1, w_op2;
  logic w_half, w_word, w_dbl, w_store, w_signed, w_fence, w_misal, w_accept;
  logic [1:0]        w_size;

  assign w_flg    = lsu_exeparam[EXE_DW-1 -: 13];
  assign w_rd0    = lsu_exeparam[c_RD_LSB +: c_RD_W];
  assign w_op1    = lsu_exeparam[127:64];
  assign w_op2    = lsu_exeparam[63:0];
  assign w_half   = w_flg[11] | w_flg[7] | w_flg[4];
  assign w_word   = w_flg[10] | w_flg[6] | w_flg[3];
  assign w_dbl    = w_flg[9]  | w_flg[2];
  assign w_store  = w_flg[5]  | w_flg[4] | w_flg[3] | w_flg[2];
  assign w_signed = w_flg[12] | w_flg[11] | w_flg[10];
  assign w_fence  = w_flg[1]  | w_flg[0];
  assign w_size   = w_dbl ? 2'd3 : w_word ? 2'd2 : w_half ? 2'd1 : 2'd0;
  assign w_misal  = ~w_fence & ((w_half & w_op1[0]) | (w_word & (|w_op1[1:0])) |
                                (w_dbl & (|w_op1[2:0])));
  assign w_accept = (r_state == S_IDLE) & lsu_exeparam_valid & ~flush;

  // Latched operation
  logic [63:0]       r_addr, r_wdata;
  logic [1:0]        r_size;
  logic              r_signed, r_store, r_flushed;
  logic [c_RD_W-1:0] r_wb_rd0;
  logic [63:0]       r_wb_res;
  logic              r_wb_misalign, r_wb_fence_i;

  logic [5:0]  w_shamt;
  logic [63:0] w_lane, w_ld_res;
  logic [7:0]  w_mask;
  logic        w_req, w_load_dead;

  assign w_shamt     = {r_addr[2:0], 3'b000};
  assign w_lane      = mem_rsp_rdata >> w_shamt;
  assign w_req       = (r_state == S_REQ);
  // A flushed load still owns the bus until its response returns
  assign w_load_dead = ~r_store & (flush | r_flushed);

  always_comb begin
    w_ld_res = w_lane;
    case (r_size)
      2'd0:    w_ld_res = r_signed ? {{56{w_lane[7]}},  w_lane[7:0]}  : {56'd0, w_lane[7:0]};
      2'd1:    w_ld_res = r_signed ? {{48{w_lane[15]}}, w_lane[15:0]} : {48'd0, w_lane[15:0]};
      2'd2:    w_ld_res = r_signed ? {{32{w_lane[31]}}, w_lane[31:0]} : {32'd0, w_lane[31:0]};
      default: w_ld_res = w_lane;
    endcase
  end

  always_comb begin
    w_mask = 8'h01;
    case (r_size)
      2'd1:    w_mask = 8'h03;
      2'd2:    w_mask = 8'h0F;
      2'd3:    w_mask = 8'hFF;
      default: w_mask = 8'h01;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (w_fence | w_misal) ? S_WB : S_REQ;
      S_REQ:   if (mem_req_ready) w_state_nxt = w_load_dead ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (w_load_dead)        w_state_nxt = mem_rsp_valid ? S_IDLE : S_DRAIN;
        else if (mem_rsp_valid) w_state_nxt = S_WB;
      end
      S_WB:    w_state_nxt = S_IDLE;
      S_DRAIN: if (mem_rsp_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_size        <= '0;
      r_signed      <= 1'b0;
      r_store       <= 1'b0;
      r_flushed     <= 1'b0;
      r_wb_rd0      <= '0;
      r_wb_res      <= '0;
      r_wb_misalign <= 1'b0;
      r_wb_fence_i  <= 1'b0;
    end else if (w_accept) begin
      r_addr        <= w_op1;
      r_wdata       <= w_op2;
      r_size        <= w_size;
      r_signed      <= w_signed;
      r_store       <= w_store;
      r_flushed     <= 1'b0;
      r_wb_rd0      <= w_rd0;
      r_wb_res      <= w_misal ? w_op1 : 64'd0;
      r_wb_misalign <= w_misal;
      r_wb_fence_i  <= w_flg[1];
    end else begin
      if (w_req && flush) r_flushed <= 1'b1;
      if ((r_state == S_WAIT) && mem_rsp_valid) r_wb_res <= r_store ? 64'd0 : w_ld_res;
    end
  end

  assign lsu_exeparam_ready = (r_state == S_IDLE) & ~lsu_exeparam_valid;

  assign mem_req_valid = w_req;
  assign mem_req_addr  = w_req ? {r_addr[63:3], 3'b000} : 64'd0;
  assign mem_req_wen   = w_req & r_store;
  assign mem_req_wdata = (w_req & r_store) ? (r_wdata << w_shamt) : 64'd0;
  assign mem_req_wstrb = (w_req & r_store) ? (w_mask << r_addr[2:0]) : 8'h00;

  // Stores are committed at issue; only loads and fences are cancelled by flush
  assign lsu_wb_valid    = (r_state == S_WB) & ~(flush & ~r_store);
  assign lsu_wb_rd0      = r_wb_rd0;
  assign lsu_wb_res      = r_wb_res;
  assign lsu_wb_misalign = r_wb_misalign & lsu_wb_valid;
  assign lsu_wb_fence_i  = r_wb_fence_i & lsu_wb_valid;

endmodule
`default_nettype wire

// File: doc/lsu_exe.md
Name: lsu_exe

Overview:
- LSU execute stage; the consumer end of the lsu_exeparam valid/ready interface driven by the LSU issue stage.
- Captures one issued load/store/fence beat and performs the memory access on a single-outstanding request/response bus.
- Aligns and extends load data, then produces a one-cycle registered writeback pulse toward the regfile/commit logic.

Parameters:
- RB, 2, rename-buffer index bits; rd0 width is 5+RB.
- EXE_DW, 13+5+RB+128, exeparam width.
- Field order, MSB to LSB: lb, lh, lw, ld, lbu, lhu, lwu, sb, sh, sw, sd, fence_i, fence, rd0, op1 (address), op2 (store data).

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- lsu_exeparam_valid  in  1  issued beat present (one-cycle pulse)
- lsu_exeparam  in  EXE_DW  issued operation
- lsu_exeparam_ready  out  1  issue may launch a beat next cycle
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  64  address, low 3 bits forced to 0
- mem_req_wen  out  1  1 = store
- mem_req_wdata  out  64  lane-shifted store data
- mem_req_wstrb  out  8  byte strobes
- mem_rsp_valid  in  1  response; exactly one per accepted request
- mem_rsp_rdata  in  64  aligned doubleword read data
- lsu_wb_valid  out  1  writeback pulse
- lsu_wb_rd0  out  5+RB  destination
- lsu_wb_res  out  64  result
- lsu_wb_misalign  out  1  misaligned-access flag, qualified by lsu_wb_valid
- lsu_wb_fence_i  out  1  fence.i completed, qualified by lsu_wb_valid
- flush  in  1  pipeline flush

Behaviour:
- Reset: state=IDLE; all outputs 0, except lsu_exeparam_ready=1 (IDLE, no valid).
- States: IDLE, REQ, WAIT, WB, DRAIN.
- Handshake: lsu_exeparam_ready = (state==IDLE) & ~lsu_exeparam_valid.
  - Issue samples ready one cycle before asserting valid.
  - Any valid beat seen in IDLE is captured regardless of the same-cycle ready value.
  - A valid beat seen outside IDLE is a protocol violation; the bench asserts it never occurs.
- IDLE + valid + ~flush: latch the beat.
  - fence/fence_i -> WB.
  - Misaligned access -> WB with misalign=1, res=op1. No memory request is issued.
    - Misaligned means: lh/lhu/sh with addr[0]!=0; lw/lwu/sw with addr[1:0]!=0; ld/sd with addr[2:0]!=0.
  - Otherwise -> REQ.
- IDLE + valid + flush: beat dropped, stay IDLE.
- REQ: mem_req_valid=1. Signals hold stable until mem_req_ready.
  - Store wdata = op2 << 8*addr[2:0]; wstrb = {1,3,15,255} << addr[2:0] for b/h/w/d.
  - Handshake -> WAIT.
- WAIT: on mem_rsp_valid -> WB.
  - Load result: byte/half/word at lane addr[2:0], sign-extended (lb/lh/lw) or zero-extended (lbu/lhu/lwu). ld passes through.
  - Store result = 0.
- WB: lsu_wb_valid=1 for exactly one cycle with rd0/res/flags -> IDLE.
  - Writeback outputs are registered; in IDLE/REQ/WAIT, lsu_wb_valid=0.
- Flush semantics: stores are already committed when issued, so flush never cancels a store.
  - Load in REQ or WAIT on flush: the request still completes (requests are not withdrawable), then -> DRAIN. The response is discarded and no writeback occurs.
  - Flush in WB on a load suppresses lsu_wb_valid.
  - Fence in WB on flush suppresses lsu_wb_valid.
  - DRAIN: leave on mem_rsp_valid -> IDLE.
  - Flush in REQ with same-cycle mem_req_ready -> DRAIN.
- Latency, aligned load with zero-wait memory: accept t, request t+1, response t+2, wb_valid t+3.
- Fence latency: accept t, wb_valid t+1.
- Reset asserted mid-transaction: immediate return to IDLE, outputs cleared. The memory side is reset together.

Test Plan:
- lb with op1=0x1003 and rdata=0x0000_0000_80FF_0000 (byte 3 = 0x80) -> mem_req_addr=0x1000, wen=0; wb res=0xFFFF_FFFF_FFFF_FF80. Same stimulus with lbu -> res=0x80.
- sh with op1=0x2006, op2=0xABCD -> mem_req_addr=0x2000, wstrb=0xC0, wdata=0xABCD_0000_0000_0000; wb_valid with res=0.
- lw with op1=0x3002 -> no mem_req_valid; wb_valid next cycle with misalign=1, res=0x3002.
- ld accepted, flush asserted in WAIT, response 3 cycles later -> no wb_valid; ready returns to 1 only after the response. sd under the same flush still produces wb_valid.
- Back-to-back valid pulses from an issue model that obeys ready -> every beat is captured exactly once. The issue model stalls (ready=0) from the accept cycle until the cycle after WB.
- mem_req_ready held low 5 cycles during a store -> addr/wdata/wstrb stay stable. RSTn pulsed low in WAIT -> state IDLE, all outputs 0, ready=1.
